// File: rtl/i_exp_pipe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i_exp_pipe_pkg : shared defaults and lane packing helpers for i_exp_pipe
// Revision: 1.0
// ----------------------------------------------------------------------------
package i_exp_pipe_pkg;

  localparam int C_W_DEF           = 32;
  localparam int C_LANES_DEF       = 4;
  localparam int C_RECIP_SHIFT_DEF = 30;

  function automatic int packed_width(input int lanes, input int w);
    return lanes * w;
  endfunction

  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i_exp_lane.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i_exp_lane : four-stage integer exp datapath for a single lane
// Revision: 1.0
// ----------------------------------------------------------------------------
module i_exp_lane #(
  parameter int W           = 32,
  parameter int BITS_SEL    = 0,
  parameter int RECIP_SHIFT = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_q_in,
  input  logic [W-1:0] i_q_b,
  input  logic [W-1:0] i_q_c,
  input  logic [W-1:0] i_q_ln2,
  input  logic [W-1:0] i_ln2_recip,
  output logic [W-1:0] o_out,
  output logic         o_clamp
);

  // S1 : clamp to non-positive and estimate z0 = a / q_ln2 via reciprocal
  logic [W-1:0]   w_a;
  logic           w_pos;
  logic [2*W-1:0] w_prod;

  assign w_pos  = !i_q_in[W-1] && (|i_q_in);
  assign w_a    = i_q_in[W-1] ? (~i_q_in + 1'b1) : '0;
  assign w_prod = {{W{1'b0}}, w_a} * {{W{1'b0}}, i_ln2_recip};

  logic [W-1:0] r_a, r_z0;
  logic         r_c1;

  // S2 : single correction step on the reciprocal estimate
  logic [W-1:0] w_zq, w_r0, w_r, w_z;
  logic         w_corr;

  assign w_zq   = r_z0 * i_q_ln2;
  assign w_r0   = r_a - w_zq;
  assign w_corr = (w_r0 >= i_q_ln2);
  assign w_r    = w_corr ? (w_r0 - i_q_ln2) : w_r0;
  assign w_z    = w_corr ? (r_z0 + 1'b1) : r_z0;

  logic [W-1:0] r_z2, r_qp;
  logic         r_c2;

  // S3 : second-order polynomial on the remainder, wide signed square
  logic signed [W:0]     w_t;
  logic signed [2*W+1:0] w_sq, w_qc_ext;

  assign w_t      = $signed({r_qp[W-1], r_qp}) + $signed({i_q_b[W-1], i_q_b});
  assign w_sq     = (w_t * w_t) >>> BITS_SEL;
  assign w_qc_ext = $signed({{(W+2){i_q_c[W-1]}}, i_q_c});

  logic [W-1:0] r_ql, r_z3;
  logic         r_c3;

  logic [W-1:0] r_out;
  logic         r_c4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_z0  <= '0;
      r_c1  <= 1'b0;
      r_z2  <= '0;
      r_qp  <= '0;
      r_c2  <= 1'b0;
      r_ql  <= '0;
      r_z3  <= '0;
      r_c3  <= 1'b0;
      r_out <= '0;
      r_c4  <= 1'b0;
    end else if (i_en) begin
      r_a   <= w_a;
      r_z0  <= W'(w_prod >> RECIP_SHIFT);
      r_c1  <= w_pos;
      r_z2  <= w_z;
      r_qp  <= ~w_r + 1'b1;
      r_c2  <= r_c1;
      r_ql  <= W'(w_sq + w_qc_ext);
      r_z3  <= r_z2;
      r_c3  <= r_c2;
      // S4 : scale by 2^-z; shifts of W or more flush to zero
      r_out <= (r_z3 >= W'(W)) ? '0 : (r_ql >> r_z3);
      r_c4  <= r_c3;
    end
  end

  assign o_out   = r_out;
  assign o_clamp = r_c4;

endmodule
`default_nettype wire

// File: rtl/i_exp_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i_exp_pipe : multi-lane pipelined integer exp with global-stall handshake
// Revision: 1.0
// ----------------------------------------------------------------------------
module i_exp_pipe
  import i_exp_pipe_pkg::*;
#(
  parameter int W           = C_W_DEF,
  parameter int LANES       = C_LANES_DEF,
  parameter int BITS_SEL    = 0,
  parameter int RECIP_SHIFT = C_RECIP_SHIFT_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_we,
  input  logic [W-1:0]                        cfg_q_b,
  input  logic [W-1:0]                        cfg_q_c,
  input  logic [W-1:0]                        cfg_q_ln2,
  input  logic [W-1:0]                        cfg_ln2_recip,
  output logic                                cfg_ready,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [packed_width(LANES, W)-1:0]   in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [packed_width(LANES, W)-1:0]   out_data,
  output logic [LANES-1:0]                    out_clamp,
  output logic                                busy
);

  logic [W-1:0] r_q_b, r_q_c, r_q_ln2, r_ln2_recip;
  logic [3:0]   r_valid;
  logic         w_adv;
  logic         w_cfg_load;

  // One shared advance: every stage moves together or all hold
  assign w_adv      = !r_valid[3] || out_ready;
  assign in_ready   = w_adv;
  assign out_valid  = r_valid[3];
  assign busy       = |r_valid;
  assign cfg_ready  = !busy && !in_valid;
  assign w_cfg_load = cfg_we && cfg_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_adv) begin
      r_valid <= {r_valid[2:0], in_valid};
    end
  end

  // Constants only change with an empty pipe, so lanes read them live
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_b       <= '0;
      r_q_c       <= '0;
      r_q_ln2     <= {{(W-1){1'b0}}, 1'b1};
      r_ln2_recip <= {{(W-1){1'b0}}, 1'b1} << RECIP_SHIFT;
    end else if (w_cfg_load) begin
      r_q_b       <= cfg_q_b;
      r_q_c       <= cfg_q_c;
      r_q_ln2     <= cfg_q_ln2;
      r_ln2_recip <= cfg_ln2_recip;
    end
  end

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      i_exp_lane #(
        .W           (W),
        .BITS_SEL    (BITS_SEL),
        .RECIP_SHIFT (RECIP_SHIFT)
      ) u_lane (
        .clk         (clk),
        .rst         (rst),
        .i_en        (w_adv),
        .i_q_in      (in_data[lane_lsb(g, W) +: W]),
        .i_q_b       (r_q_b),
        .i_q_c       (r_q_c),
        .i_q_ln2     (r_q_ln2),
        .i_ln2_recip (r_ln2_recip),
        .o_out       (out_data[lane_lsb(g, W) +: W]),
        .o_clamp     (out_clamp[g])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_i_exp_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_i_exp_pipe : scoreboard bench for i_exp_pipe with arithmetic reference
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_i_exp_pipe;
  import i_exp_pipe_pkg::*;

  localparam int W     = C_W_DEF;
  localparam int LANES = C_LANES_DEF;
  localparam int RS    = C_RECIP_SHIFT_DEF;
  localparam int BS    = 0;
  localparam int PW    = LANES * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [W-1:0]  cfg_q_b = '0, cfg_q_c = '0, cfg_q_ln2 = '0, cfg_ln2_recip = '0;
  logic          cfg_ready;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [PW-1:0] out_data;
  logic [LANES-1:0] out_clamp;
  logic          busy;

  i_exp_pipe #(.W(W), .LANES(LANES), .BITS_SEL(BS), .RECIP_SHIFT(RS)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_q_b(cfg_q_b), .cfg_q_c(cfg_q_c),
    .cfg_q_ln2(cfg_q_ln2), .cfg_ln2_recip(cfg_ln2_recip), .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_clamp(out_clamp), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0]    data;
    logic [LANES-1:0] clamp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;  // 0 high, 1 toggle, 2 random, 3 low
  logic [W-1:0] m_qb, m_qc, m_qln2, m_recip;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Exp of a non-positive integer: split into z*ln2 + r, polynomial on -r, scale by 2^-z
  function automatic logic [W:0] ref_lane(input logic [W-1:0] q);
    longint              qs, qp, t;
    longint unsigned     a, z0, z, r, mask;
    logic signed [127:0] big, qcx;
    logic [W-1:0]        l, o;
    mask = (64'd1 << W) - 1;
    qs   = longint'($signed(q));
    a    = (qs < 0) ? longint'(-qs) : 64'd0;
    z0   = ((a * 64'(m_recip)) >> RS) & mask;
    r    = a - z0 * 64'(m_qln2);
    if (r >= 64'(m_qln2)) begin
      z = z0 + 1;
      r = r - 64'(m_qln2);
    end else begin
      z = z0;
    end
    qp  = -longint'(r);
    t   = qp + longint'($signed(m_qb));
    big = t;
    big = big * big;
    big = big >>> BS;
    qcx = longint'($signed(m_qc));
    big = big + qcx;
    l   = big[W-1:0];
    o   = (z >= 64'(W)) ? '0 : (l >> z);
    return {(qs > 0), o};
  endfunction

  function automatic exp_t model_beat(input logic [PW-1:0] d);
    exp_t       e;
    logic [W:0] r;
    for (int i = 0; i < LANES; i++) begin
      r = ref_lane(d[lane_lsb(i, W) +: W]);
      e.data[lane_lsb(i, W) +: W] = r[W-1:0];
      e.clamp[i] = r[W];
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rand_in();
    int v;
    case ($urandom_range(0, 5))
      0:       v = -int'($urandom_range(0, 200));
      1:       v = -int'($urandom_range(0, 1 << 20));
      2:       v = int'($urandom);
      3:       v = int'($urandom_range(1, 1000));
      4:       v = 32'h8000_0000;
      default: v = 0;
    endcase
    return W'(v);
  endfunction

  function automatic logic [PW-1:0] rand_beat();
    logic [PW-1:0] d;
    for (int i = 0; i < LANES; i++) d[lane_lsb(i, W) +: W] = rand_in();
    return d;
  endfunction

  function automatic logic [PW-1:0] pack(input int l0, input int l1, input int l2, input int l3);
    return {W'(l3), W'(l2), W'(l1), W'(l0)};
  endfunction

  // All tasks start and end at 1 time unit after a rising edge
  task automatic send_beat(input logic [PW-1:0] d);
    int   n;
    logic rdy;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 300) break;
    end
    if (rdy) begin
      sb.push_back(model_beat(d));
    end else begin
      checks++;
      errors++;
      $display("FAIL in_accept_timeout: in_ready stayed %0b, required 1", in_ready);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 500) begin
      idle(1);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
    end
  endtask

  task automatic do_cfg(input logic [W-1:0] qb, input logic [W-1:0] qc,
                        input logic [W-1:0] qln2, input logic [W-1:0] recip);
    logic acc;
    acc = (sb.size() == 0) && !in_valid;
    cfg_we = 1'b1;
    cfg_q_b = qb; cfg_q_c = qc; cfg_q_ln2 = qln2; cfg_ln2_recip = recip;
    @(negedge clk);
    chk("cfg_ready", 160'(cfg_ready), 160'(acc));
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    if (acc) begin
      m_qb = qb; m_qc = qc; m_qln2 = qln2; m_recip = recip;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    idle(3);
    rst = 1'b0;
    m_qb = '0; m_qc = '0; m_qln2 = W'(1); m_recip = W'(64'd1 << RS);
    chk("in_ready_after_rst", 160'(in_ready), 160'(1));
  endtask

  task automatic latency_beat(input logic [PW-1:0] d, input string name);
    int n;
    send_beat(d);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (out_valid || n > 20) break;
    end
    chk(name, 160'(n), 160'(4));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] recip_of(input logic [W-1:0] q);
    return W'((64'd1 << RS) / 64'(q));
  endfunction

  // out_ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output transfer, checks stall stability
  logic             mon_stall = 1'b0;
  logic [PW-1:0]    mon_d;
  logic [LANES-1:0] mon_c;
  exp_t             mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_stall = 1'b0;
      end else begin
        if (mon_stall) begin
          chk("stall_valid_held", 160'(out_valid), 160'(1));
          chk("stall_data_held", 160'({out_clamp, out_data}), 160'({mon_c, mon_d}));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got data %0h, required no output", out_data);
          end else begin
            mon_e = sb.pop_front();
            chk("out_data", 160'(out_data), 160'(mon_e.data));
            chk("out_clamp", 160'(out_clamp), 160'(mon_e.clamp));
          end
        end
        mon_stall = out_valid && !out_ready;
        mon_d = out_data;
        mon_c = out_clamp;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(1);
    do_reset();
    chk("rst_out_valid", 160'(out_valid), 160'(0));
    chk("rst_busy", 160'(busy), 160'(0));
    chk("rst_out_clamp", 160'(out_clamp), 160'(0));
    chk("rst_out_data", 160'(out_data), 160'(0));
    chk("rst_cfg_ready", 160'(cfg_ready), 160'(1));

    // Reset constants give well-defined z
    latency_beat(pack(-3, 0, 17, -100), "lat_reset_cfg");
    drain();

    do_cfg(W'(0), W'(0), W'(5), recip_of(W'(5)));
    latency_beat(pack(-12, -12, -7, 0), "lat_basic");
    latency_beat(pack(0, 7, 0, 0), "lat_clamp");
    latency_beat(pack(-1000, -1000, 32'h8000_0000, -1), "lat_big_z");
    drain();

    // Streaming under alternating backpressure
    ready_mode = 1;
    for (int i = 0; i < 10; i++) send_beat(rand_beat());
    drain();
    ready_mode = 0;
    idle(1);

    // Configuration while busy is dropped, after drain it takes effect
    send_beat(pack(-12, -30, 5, -2));
    chk("busy_while_inflight", 160'(busy), 160'(1));
    do_cfg(W'(3), W'(100), W'(7), recip_of(W'(7)));
    send_beat(pack(-12, -30, 5, -2));
    drain();
    idle(1);
    do_cfg(W'(-4), W'(9), W'(11), recip_of(W'(11)));
    latency_beat(pack(-12, -30, 5, -2), "lat_new_cfg");
    drain();

    // cfg_we coinciding with an input beat loses
    cfg_we = 1'b1;
    cfg_q_b = W'(77); cfg_q_c = W'(1); cfg_q_ln2 = W'(2); cfg_ln2_recip = recip_of(W'(2));
    send_beat(pack(-40, -41, -42, 3));
    cfg_we = 1'b0;
    send_beat(pack(-40, -41, -42, 3));
    drain();
    idle(1);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) send_beat(rand_beat());
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_valid_after_rst", 160'(out_valid), 160'(0));
    end
    @(posedge clk);
    #1;
    latency_beat(pack(-12, 7, -1000, 0), "lat_after_rst");
    drain();

    // Randomized traffic with random backpressure and periodic reconfiguration
    ready_mode = 2;
    for (int i = 0; i < 200; i++) begin
      if (i % 40 == 0) begin
        logic [W-1:0] q;
        drain();
        idle(1);
        q = W'($urandom_range(1, 1 << 16));
        do_cfg(W'($urandom), W'($urandom), q, recip_of(q));
      end
      send_beat(rand_beat());
      idle($urandom_range(0, 2));
    end
    drain();
    ready_mode = 0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
